user_input_checker: RTL and testbench
=====================================

// Module: user_input_checker
// PURPOSE
// Upstream stage of the round counter in the memory game. Debounces the player's
// buttons, compares each accepted press with the expected sequence element, and
// pulses the round counter's enable (E) once per correct press. It consumes the
// counter's terminal-count (tc) to end the round. It flags wrong-key, multi-key and
// timeout errors to the game controller.
// PARAMETERS
// P_KEYS      4    number of buttons; seq_data and keys are one-hot of this width
// P_ADDR      4    width of the sequence index seq_addr
// P_DEBOUNCE  4    consecutive stable cycles required to accept a press or release
// P_TIMEOUT   200  idle cycles allowed in WAIT_KEY before a timeout error
// PORTS
// clk       in   1        system clock, rising edge
// R         in   1        reset: synchronous, active-high
// start     in   1        begin a round; sampled in IDLE, DONE or ERROR only
// keys      in   P_KEYS   raw buttons, active-high, asynchronous to clk
// seq_data  in   P_KEYS   expected one-hot key at seq_addr; valid 1 cycle after seq_addr changes
// tc_in     in   1        terminal count from the round counter
// seq_addr  out  P_ADDR   index of the expected element
// cnt_E     out  1        1-cycle pulse per correct press; drives the counter's E
// cnt_clr   out  1        1-cycle pulse on accepted start; drives the counter's R
// busy      out  1        1 in every state except IDLE, DONE and ERROR
// done      out  1        1 while in DONE
// err       out  1        1 while in ERROR
// err_code  out  2        00 none, 01 wrong key, 10 multi-key, 11 timeout; held in ERROR
// BEHAVIOUR
// - Reset (R=1 at clk edge, all states):
//   - State goes to IDLE.
//   - All outputs are 0; seq_addr=0 and err_code=00.
//   - The synchroniser, debounce counter and timeout counter clear.
//   - Reset overrides start.
// - keys pass through a 2-FF synchroniser (ks); all decisions use ks.
// - Debounce counter: loads 0 whenever ks differs from its previous value, else
//   increments and saturates at P_DEBOUNCE. A value is stable when the count equals P_DEBOUNCE.
// - IDLE, DONE, ERROR, on start=1:
//   - cnt_clr=1 for 1 cycle; seq_addr<=0; err_code<=00; timeout counter<=0.
//   - Next state is WAIT_KEY.
// - WAIT_KEY:
//   - Timeout counter increments every cycle.
//   - When it reaches P_TIMEOUT-1 with no stable nonzero ks: ERROR with err_code=11.
//   - When ks is stable and nonzero: CHECK. If both conditions hold in the same cycle,
//     the press wins.
// - CHECK (1 cycle), evaluated in this order:
//   - popcount(ks)>1: ERROR, err_code=10.
//   - ks!=seq_data: ERROR, err_code=01.
//   - Otherwise: cnt_E=1 this cycle, seq_addr<=seq_addr+1 (wraps modulo 2^P_ADDR),
//     next state WAIT_REL.
// - WAIT_REL:
//   - Waits for ks==0 stable. Key changes while held are ignored (no error).
//   - On stable release: tc_in=1 goes to DONE; tc_in=0 clears the timeout counter and goes to WAIT_KEY.
//   - The release time covers the counter's 1-cycle tc latency.
// - start while busy=1 is ignored. Keys are ignored in IDLE, DONE and ERROR.
// - R asserted mid-round aborts with no cnt_E pulse. The round counter must be cleared
//   by the controller or by the next cnt_clr.
// - Latency:
//   - Stable press to cnt_E: P_DEBOUNCE+3 cycles from the first synchronised edge.
//   - Each output is registered.
// TESTING
// 1. Reset: R=1 for 2 cycles while keys=4'b0101 and start=1 -> IDLE, all outputs 0, seq_addr=0.
// 2. Correct round: seq=3 elements (0001,0100,0010), counter data=2, clean presses/releases
//    -> 3 cnt_E pulses, seq_addr 0->3, done=1, err=0.
// 3. Wrong key: expected 0010, press 1000 -> err=1, err_code=01, no cnt_E pulse, seq_addr unchanged.
// 4. Multi-key: press 0011 -> err_code=10. Bounce: 0001 toggling every 2 cycles for 10 cycles
//    -> no CHECK until stable for 4 cycles.
// 5. Timeout: no press for 200 cycles after start -> err_code=11 at cycle 200. Then start=1
//    -> cnt_clr pulse, err=0, seq_addr=0.
// 6. Mid-round R: R=1 during WAIT_REL -> IDLE next cycle, no cnt_E. start=1 while busy -> ignored.

Source files
------------

// File: rtl/user_input_checker.sv
// Player input checker for the memory game: debounces buttons, checks each
// press against the expected sequence and drives the round counter.
module user_input_checker #(
   parameter int P_KEYS     = 4,
   parameter int P_ADDR     = 4,
   parameter int P_DEBOUNCE = 4,
   parameter int P_TIMEOUT  = 200
) (
   input  logic              clk,
   input  logic              R,
   input  logic              start,
   input  logic [P_KEYS-1:0] keys,
   input  logic [P_KEYS-1:0] seq_data,
   input  logic              tc_in,
   output logic [P_ADDR-1:0] seq_addr,
   output logic              cnt_E,
   output logic              cnt_clr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int DW = $clog2(P_DEBOUNCE + 1);
   localparam int TW = $clog2(P_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_KEY, S_CHECK, S_WAIT_REL, S_DONE, S_ERROR
   } state_t;

   state_t state, nstate;

   logic [P_KEYS-1:0] s1, ks, kprev;
   logic [DW-1:0]     dcnt;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic              stable, pressed, released, multi, tmo;
   logic [P_ADDR-1:0] addr_n;
   logic              e_n, clr_n, busy_n, done_n, err_n;
   logic [1:0]        code_n;

   always_ff @(posedge clk) begin
      if (R) begin
         s1    <= '0;
         ks    <= '0;
         kprev <= '0;
         dcnt  <= '0;
      end else begin
         s1    <= keys;
         ks    <= s1;
         kprev <= ks;
         if (ks != kprev)
            dcnt <= '0;
         else if (dcnt != DW'(P_DEBOUNCE))
            dcnt <= dcnt + 1'b1;
      end
   end

   // A count left over from the previous value must not vouch for a fresh edge
   assign stable   = (dcnt == DW'(P_DEBOUNCE)) && (ks == kprev);
   assign pressed  = stable && (ks != '0);
   assign released = stable && (ks == '0);
   assign multi    = (ks & (ks - 1'b1)) != '0;
   assign tmo      = (tcnt == TW'(P_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (R) begin
         state    <= S_IDLE;
         seq_addr <= '0;
         cnt_E    <= 1'b0;
         cnt_clr  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         tcnt     <= '0;
      end else begin
         state    <= nstate;
         seq_addr <= addr_n;
         cnt_E    <= e_n;
         cnt_clr  <= clr_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
         err_code <= code_n;
         tcnt     <= tcnt_n;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR:
            if (start) nstate = S_WAIT_KEY;
         S_WAIT_KEY:
            if (pressed)  nstate = S_CHECK;
            else if (tmo) nstate = S_ERROR;
         S_CHECK:
            if (multi || ks != seq_data) nstate = S_ERROR;
            else                         nstate = S_WAIT_REL;
         S_WAIT_REL:
            if (released) nstate = tc_in ? S_DONE : S_WAIT_KEY;
         default:
            nstate = S_IDLE;
      endcase
   end

   always_comb begin
      addr_n = seq_addr;
      e_n    = 1'b0;
      clr_n  = 1'b0;
      code_n = err_code;
      tcnt_n = tcnt;
      busy_n = !(nstate inside {S_IDLE, S_DONE, S_ERROR});
      done_n = (nstate == S_DONE);
      err_n  = (nstate == S_ERROR);
      unique case (state)
         S_IDLE, S_DONE, S_ERROR:
            if (start) begin
               clr_n  = 1'b1;
               addr_n = '0;
               code_n = 2'b00;
               tcnt_n = '0;
            end
         S_WAIT_KEY: begin
            tcnt_n = tcnt + 1'b1;
            if (!pressed && tmo) code_n = 2'b11;
         end
         S_CHECK:
            if (multi)                 code_n = 2'b10;
            else if (ks != seq_data)   code_n = 2'b01;
            else begin
               e_n    = 1'b1;
               addr_n = seq_addr + 1'b1;
            end
         S_WAIT_REL:
            if (released && !tc_in) tcnt_n = '0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_user_input_checker.sv
// Scoreboard bench for user_input_checker: stimulus pushes predicted
// events, a negedge monitor pops and compares them.
module tb_user_input_checker;

   localparam int P_DEB = 4;
   localparam int P_TO  = 200;

   localparam int EV_CLR  = 0;
   localparam int EV_E    = 1;
   localparam int EV_DONE = 2;
   localparam int EV_ERR  = 3;

   logic       clk = 1'b0;
   logic       R = 1'b1;
   logic       start = 1'b0;
   logic [3:0] keys = 4'b0000;
   logic [3:0] seq_data = 4'b0000;
   logic       tc_in;
   logic [3:0] seq_addr;
   logic       cnt_E, cnt_clr, busy, done, err;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   user_input_checker dut (
      .clk(clk), .R(R), .start(start), .keys(keys),
      .seq_data(seq_data), .tc_in(tc_in), .seq_addr(seq_addr),
      .cnt_E(cnt_E), .cnt_clr(cnt_clr), .busy(busy), .done(done),
      .err(err), .err_code(err_code)
   );

   typedef struct {
      int kind;
      int addr;
      int code;
      int t0;
      int lat;
   } ev_t;

   ev_t  q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [3:0] seq_mem [16];
   int   idx, len, t_clr;
   bit   ended;
   logic done_q = 1'b0;
   logic err_q = 1'b0;

   // Round counter stand-in: tc rises one cycle after the (data+1)-th enable
   int   data = 0;
   int   rc = 0;
   logic tc = 1'b0;
   assign tc_in = tc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      seq_data <= seq_mem[seq_addr];
      if (cnt_clr) begin
         rc <= 0;
         tc <= 1'b0;
      end else if (cnt_E) begin
         rc <= rc + 1;
         if (rc == data) tc <= 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int addr,
                            input int code, input int t0, input int lat);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.code = code;
      e.t0   = t0;
      e.lat  = lat;
      q.push_back(e);
   endtask

   task automatic match(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         check("unexpected_event", kind, -1);
         return;
      end
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != e.kind) return;
      if (kind != EV_CLR) check("seq_addr", int'(seq_addr), e.addr);
      if (kind == EV_ERR) check("err_code", int'(err_code), e.code);
      if (kind == EV_DONE) check("err_at_done", int'(err), 0);
      if (e.lat >= 0) check("latency", cyc - e.t0, e.lat);
   endtask

   always @(negedge clk) begin
      if (!R) begin
         if (cnt_clr) match(EV_CLR);
         if (cnt_E) match(EV_E);
         if (done && !done_q) match(EV_DONE);
         if (err && !err_q) match(EV_ERR);
      end
      done_q <= done;
      err_q  <= err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      expect_ev(EV_CLR, 0, 0, cyc, 1);
      t_clr = cyc + 1;
      idx   = 0;
      ended = 1'b0;
      tick(1);
      start = 1'b0;
      tick(12);
   endtask

   task automatic press(input logic [3:0] v, input bit bounce,
                        input bit wiggle);
      logic [3:0] want;
      int td;
      want = seq_mem[idx % 16];
      if (bounce)
         repeat (3) begin
            keys = v;
            tick(2);
            keys = 4'b0000;
            tick(2);
         end
      keys = v;
      td = cyc;
      if ($countones(v) > 1) begin
         expect_ev(EV_ERR, idx % 16, 2, 0, -1);
         ended = 1'b1;
      end else if (v != want) begin
         expect_ev(EV_ERR, idx % 16, 1, 0, -1);
         ended = 1'b1;
      end else begin
         idx++;
         expect_ev(EV_E, idx % 16, 0, td + 2, P_DEB + 3);
         if (idx == len) begin
            expect_ev(EV_DONE, idx % 16, 0, 0, -1);
            ended = 1'b1;
         end
      end
      tick(12);
      if (wiggle) keys = 4'($urandom_range(1, 15));
      tick(4);
      keys = 4'b0000;
      tick(14);
   endtask

   task automatic idle_timeout();
      expect_ev(EV_ERR, idx % 16, 3, t_clr, (idx == 0) ? P_TO : -1);
      ended = 1'b1;
      tick(P_TO + 20);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
      check("drain_queue", q.size(), 0);
   endtask

   task automatic new_seq(input int n);
      len  = n;
      data = n - 1;
      for (int k = 0; k < 16; k++)
         seq_mem[k] = 4'(1 << $urandom_range(0, 3));
   endtask

   initial begin
      logic [3:0] v, want;
      int rr, s;
      for (int k = 0; k < 16; k++) seq_mem[k] = 4'b0001;
      keys  = 4'b0101;
      start = 1'b1;
      tick(2);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_err_code", int'(err_code), 0);
      check("rst_seq_addr", int'(seq_addr), 0);
      check("rst_cnt_E", int'(cnt_E), 0);
      check("rst_cnt_clr", int'(cnt_clr), 0);
      R = 1'b0;
      start = 1'b0;
      keys = 4'b0000;
      tick(10);

      new_seq(3);
      seq_mem[0] = 4'b0001;
      seq_mem[1] = 4'b0100;
      seq_mem[2] = 4'b0010;
      do_start();
      press(4'b0001, 1'b0, 1'b0);
      press(4'b0100, 1'b0, 1'b0);
      press(4'b0010, 1'b0, 1'b0);
      drain();
      check("round_done", int'(done), 1);
      check("round_err", int'(err), 0);
      check("round_addr", int'(seq_addr), 3);
      check("round_busy", int'(busy), 0);

      seq_mem[0] = 4'b0010;
      do_start();
      press(4'b1000, 1'b0, 1'b0);
      drain();
      check("wrong_err", int'(err), 1);
      check("wrong_code", int'(err_code), 1);

      do_start();
      press(4'b0011, 1'b0, 1'b0);
      drain();

      new_seq(1);
      seq_mem[0] = 4'b0001;
      do_start();
      press(4'b0001, 1'b1, 1'b0);
      drain();

      new_seq(3);
      do_start();
      idle_timeout();
      drain();
      do_start();
      check("restart_err", int'(err), 0);
      check("restart_addr", int'(seq_addr), 0);
      check("restart_busy", int'(busy), 1);

      keys = seq_mem[0];
      expect_ev(EV_E, 1, 0, cyc + 2, P_DEB + 3);
      tick(11);
      R = 1'b1;
      tick(1);
      R = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_addr", int'(seq_addr), 0);
      check("abort_cnt_E", int'(cnt_E), 0);
      keys = 4'b0000;
      tick(20);
      drain();

      do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      check("busy_start_ignored", int'(busy), 1);
      press(seq_mem[0], 1'b0, 1'b1);
      idle_timeout();
      drain();

      new_seq(17);
      do_start();
      while (!ended) press(seq_mem[idx % 16], 1'b0, 1'b0);
      drain();

      for (int r = 0; r < 30; r++) begin
         new_seq($urandom_range(1, 6));
         do_start();
         while (!ended) begin
            rr = $urandom_range(0, 99);
            want = seq_mem[idx % 16];
            if (rr < 6) begin
               idle_timeout();
            end else begin
               if (rr < 16) begin
                  v = want;
                  s = $urandom_range(1, 3);
                  repeat (s) v = {v[2:0], v[3]};
               end else if (rr < 26) begin
                  do v = 4'($urandom_range(3, 15));
                  while ($countones(v) < 2);
               end else begin
                  v = want;
               end
               press(v, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
            end
         end
         drain();
      end

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
